hazard_stall_unit: RTL
======================

// Module: hazard_stall_unit
// PURPOSE
// - Pipeline hazard/stall controller for the 5-stage RV32I core; companion to the EX-stage forwarding logic.
// - Detects load-use hazards (forwarding cannot cover them), taken-branch redirects and data-memory wait states.
// - Drives write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// - Tracks memory-wait timeout and saturating performance counters.
// PARAMETERS
// - MEM_TIMEOUT  64  max consecutive DMem wait cycles before the ERROR state
// - CNT_W        16  width of the stall/flush performance counters
// PORTS
// - Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
//   clk              in   1   core clock
//   rst              in   1   asynchronous, active-high reset
// - Hazard-detection inputs:
//   ID_EX_MemRead    in   1   instruction in EX is a load
//   ID_EX_RegRd      in   5   destination of the instruction in EX
//   IF_ID_RegRs1     in   5   rs1 of the instruction in ID
//   IF_ID_RegRs2     in   5   rs2 of the instruction in ID
//   IF_ID_UseRs1     in   1   ID instruction reads rs1
//   IF_ID_UseRs2     in   1   ID instruction reads rs2
//   EX_BranchTaken   in   1   branch/jump in EX resolved taken (redirect)
//   EX_MEM_MemReq    in   1   load/store occupying MEM this cycle
//   DMemReady        in   1   data memory completes the MEM access this cycle
// - Pipeline control outputs:
//   PCWrite          out  1   PC update enable
//   IF_ID_Write      out  1   IF/ID enable
//   IF_ID_Flush      out  1   IF/ID -> NOP
//   ID_EX_Write      out  1   ID/EX enable
//   ID_EX_Flush      out  1   ID/EX -> bubble
//   EX_MEM_Write     out  1   EX/MEM enable
//   MEM_WB_Flush     out  1   MEM/WB -> bubble (RegWrite=0)
// - Status outputs:
//   MemTimeout       out  1   sticky error flag
//   StallCycles      out  CNT_W  saturating count of cycles with PCWrite=0
//   FlushEvents      out  CNT_W  saturating count of branch flushes
// BEHAVIOUR
// - FSM states: RUN, MEM_WAIT, ERROR. Reset -> RUN; WaitCnt=0; counters=0; MemTimeout=0.
// - While rst=1: all *_Write=0, all *_Flush=1.
// - memstall = EX_MEM_MemReq & !DMemReady.
// - loaduse  = ID_EX_MemRead & ID_EX_RegRd!=0 &
//   ((UseRs1 & Rs1==RegRd) | (UseRs2 & Rs2==RegRd)).
// - Controls are combinational, same-cycle; priority: ERROR > memstall > branch > loaduse > normal.
//   - ERROR/memstall: PCWrite=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0, MEM_WB_Flush=1, other flushes=0.
//     A branch in EX is held, not lost; it acts on the first non-stall cycle.
//   - branch: PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1, all writes=1. Branch squashes a coincident load-use.
//   - loaduse: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, ID_EX_Write=1, EX_MEM_Write=1. Exactly one bubble.
//   - normal: all writes=1, all flushes=0.
// - FSM transitions:
//   - RUN -> MEM_WAIT when memstall. WaitCnt counts every MEM_WAIT cycle.
//   - MEM_WAIT -> RUN when DMemReady=1 (that cycle is not stalled). WaitCnt clears on exit.
//   - MEM_WAIT -> ERROR when memstall persists and WaitCnt reaches MEM_TIMEOUT-1 (cycle MEM_TIMEOUT of the wait).
//   - ERROR exits only via rst. MemTimeout=1 registered on ERROR entry.
// - Counters:
//   - StallCycles increments each cycle with PCWrite=0 (not during rst).
//   - FlushEvents increments each branch-flush cycle.
//   - Both saturate at 2^CNT_W-1 and never wrap.
// - Async rst mid-MEM_WAIT: immediate return to RUN, WaitCnt=0, no residual stall after deassertion.
// STRUCTURE
// - Shared package hazard_pkg: typedef enum logic[1:0] {RUN, MEM_WAIT, ERROR} hz_state_t; constant REG_ZERO=5'd0.
// - Sub-module sat_counter #(W) (inc, count), instantiated twice.
// - FSM and control decode stay in this module.
// TESTING
// - Load-use: MemRead=1, RegRd=5, Rs1=5, UseRs1=1 -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for 1 cycle; StallCycles=1.
// - RegRd=0 or UseRs1=0 with Rs1 match -> no stall, all writes=1.
// - MemReq=1, DMemReady low 3 cycles then high -> 3 frozen cycles with MEM_WB_Flush=1, back to RUN, StallCycles=3.
// - Branch + load-use same cycle -> PCWrite=1, IF_ID_Flush=ID_EX_Flush=1, FlushEvents=1.
// - Branch during memstall -> held until DMemReady, then flushes.
// - MEM_TIMEOUT=4, DMemReady never -> MemTimeout=1 after 4 wait cycles, frozen; rst mid-wait clears all.
// - CNT_W=3, 10 stall cycles -> StallCycles holds at 7.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One bundle of pipeline-register controls, decoded as a unit.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NORMAL  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t CTRL_BRANCH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_LOADUSE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic logic reg_match(input logic use_rs, input logic [4:0] rs,
                                       input logic [4:0] rd);
        return use_rs && (rs == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / branch / data-memory-wait hazard controller for the 5-stage RV32I pipeline.
// Drives pipeline-register enables and flushes, tracks memory-wait timeout and perf counters.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegRd,
    input  logic [4:0]       IF_ID_RegRs1,
    input  logic [4:0]       IF_ID_RegRs2,
    input  logic             IF_ID_UseRs1,
    input  logic             IF_ID_UseRs2,
    input  logic             EX_BranchTaken,
    input  logic             EX_MEM_MemReq,
    input  logic             DMemReady,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Flush,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int unsigned      WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t          state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic               branch_pend_q, branch_pend_d;

    logic     memstall;
    logic     loaduse;
    logic     frozen;
    logic     branch;
    hz_ctrl_t ctrl;
    logic     stall_inc;
    logic     flush_inc;

    assign memstall = EX_MEM_MemReq && !DMemReady;

    assign loaduse = ID_EX_MemRead && (ID_EX_RegRd != REG_ZERO) &&
                     (reg_match(IF_ID_UseRs1, IF_ID_RegRs1, ID_EX_RegRd) ||
                      reg_match(IF_ID_UseRs2, IF_ID_RegRs2, ID_EX_RegRd));

    assign frozen = (state_q == ERROR) || memstall;

    // A redirect seen while frozen is remembered so it still fires on the first free cycle.
    assign branch = EX_BranchTaken || branch_pend_q;

    always_comb begin
        ctrl = CTRL_NORMAL;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (frozen) begin
            ctrl = CTRL_FREEZE;
        end else if (branch) begin
            ctrl = CTRL_BRANCH;
        end else if (loaduse) begin
            ctrl = CTRL_LOADUSE;
        end
    end

    assign stall_inc = !rst && !ctrl.pc_write;
    assign flush_inc = !rst && !frozen && branch;

    assign branch_pend_d = frozen ? (branch_pend_q || EX_BranchTaken) : 1'b0;

    // Wait-cycle accounting: the RUN cycle that first sees memstall is wait cycle 1.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (memstall) begin
                    if (MEM_TIMEOUT <= 1) begin
                        state_d   = ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end
                end
            end
            MEM_WAIT: begin
                // Leaving on !memstall also covers a request withdrawn mid-wait.
                if (!memstall) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ERROR;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_q     <= 1'b0;
            branch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_q     <= timeout_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .count(StallCycles)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (flush_inc),
        .count(FlushEvents)
    );

    assign PCWrite      = ctrl.pc_write;
    assign IF_ID_Write  = ctrl.if_id_write;
    assign IF_ID_Flush  = ctrl.if_id_flush;
    assign ID_EX_Write  = ctrl.id_ex_write;
    assign ID_EX_Flush  = ctrl.id_ex_flush;
    assign EX_MEM_Write = ctrl.ex_mem_write;
    assign MEM_WB_Flush = ctrl.mem_wb_flush;
    assign MemTimeout   = timeout_q;

endmodule
